// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// with the borrow carried between bits in a flip-flop.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             load_c, last_c, d_c, br_c;

  // Next state plus the two chained half-subtractor equations for the current bit
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    d_c        = sa[0] ^ sb[0] ^ br;
    br_c       = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last_c     = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath; diff/borrow_out change only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (load_c) begin
        sa  <= a;
        sb  <= b;
        acc <= '0;
        br  <= 1'b0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        acc <= {d_c, acc[WIDTH-1:1]};
        br  <= br_c;
        cnt <= cnt + CW'(1);
        if (last_c) begin
          diff       <= {d_c, acc[WIDTH-1:1]};
          borrow_out <= br_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8) against hand-computed
// results and an a-b reference.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow_out;
  logic [WIDTH-1:0] diff;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_diff;
  logic             exp_br;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, checking the held result never moves while busy; returns cycles taken
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nbusy++;
      chk("diff_hold", 32'(diff), 32'(exp_diff));
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [WIDTH-1:0] rd, input logic rb);
    int n, nb;
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(n, nb);
    chk("latency", 32'(n), 32'(WIDTH));
    chk("busy_cycles", 32'(nb), 32'(WIDTH));
    chk("diff", 32'(diff), 32'(rd));
    chk("borrow", 32'(borrow_out), 32'(rb));
    chk("busy_in_done", 32'(busy), 32'd0);
    exp_diff = rd;
    exp_br   = rb;
    tick();
    chk("done_pulse_end", 32'(done), 32'd0);
  endtask

  initial begin
    int n, nb;
    logic [WIDTH-1:0] ra, rb_v;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    exp_diff = '0; exp_br = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // T1..T3
    run_op(8'd100, 8'd58, 8'd42, 1'b0);
    run_op(8'd5, 8'd10, 8'd251, 1'b1);
    run_op(8'd0, 8'd1, 8'd255, 1'b1);
    run_op(8'd255, 8'd255, 8'd0, 1'b0);
    run_op(8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) begin
      tick();
      chk("no_spurious_done", 32'(done), 32'd0);
    end

    // T4: second start during SHIFT is ignored
    a = 8'd200; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("t4_latency", 32'(n), 32'(WIDTH - 3));
    chk("t4_diff", 32'(diff), 32'd199);
    chk("t4_borrow", 32'(borrow_out), 32'd0);
    exp_diff = 8'd199;
    tick();
    chk("t4_done_end", 32'(done), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // T5: start held across DONE gives back-to-back operations
    a = 8'd10; b = 8'd3; start = 1'b1;
    tick();
    wait_done(n, nb);
    chk("t5_lat0", 32'(n), 32'(WIDTH));
    chk("t5_diff0", 32'(diff), 32'd7);
    chk("t5_br0", 32'(borrow_out), 32'd0);
    exp_diff = 8'd7;
    a = 8'd3; b = 8'd10;
    tick();
    chk("t5_reload_busy", 32'(busy), 32'd1);
    chk("t5_reload_done", 32'(done), 32'd0);
    wait_done(n, nb);
    chk("t5_lat1", 32'(n), 32'(WIDTH));
    chk("t5_diff1", 32'(diff), 32'd249);
    chk("t5_br1", 32'(borrow_out), 32'd1);
    exp_diff = 8'd249;
    a = 8'd128; b = 8'd127;
    tick();
    wait_done(n, nb);
    chk("t5_lat2", 32'(n), 32'(WIDTH));
    chk("t5_diff2", 32'(diff), 32'd1);
    chk("t5_br2", 32'(borrow_out), 32'd0);
    exp_diff = 8'd1;
    start = 1'b0;
    tick();
    chk("t5_end_done", 32'(done), 32'd0);
    chk("t5_end_busy", 32'(busy), 32'd0);

    // T6: reset mid-SHIFT aborts and clears the result
    a = 8'd77; b = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_diff", 32'(diff), 32'd0);
    chk("t6_borrow", 32'(borrow_out), 32'd0);
    exp_diff = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_done", 32'(done), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);
    end
    run_op(8'd77, 8'd200, 8'd133, 1'b1);

    // Random sweep against the reference
    for (int i = 0; i < 1000; i++) begin
      ra   = WIDTH'($urandom_range(0, 255));
      rb_v = WIDTH'($urandom_range(0, 255));
      run_op(ra, rb_v, WIDTH'(ra - rb_v), (ra < rb_v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
